word_serializer: RTL and testbench

WORD_SERIALIZER -- requirements
Module: word_serializer

---
 rtl/comp_pkg.sv | 12 +
 rtl/word_next_sel.sv | 29 ++
 rtl/word_serializer.sv | 175 +++++++++++++++++
 tb/tb_word_serializer.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/comp_pkg.sv
// Shared definitions for the word serializer: default geometry and FSM state encoding.
package comp_pkg;

  localparam int CP_DATA_WIDTH      = 32;
  localparam int CP_WORDS_PER_ENTRY = 16;

  typedef enum logic [0:0] {
    IDLE = 1'b0,  // no line held
    SEND = 1'b1   // line held, words being emitted
  } ser_state_e;

endpackage

// File: rtl/word_next_sel.sv
// Next-nonzero-word selector for the zero-skip build (macro WORD_SER_ZERO_SKIP_EN).
// Returns the lowest set bit of mask_i and whether any bit is set. Only
// compiled when zero skipping is enabled, so the default build carries no
// zero-detect logic at all.
`ifdef WORD_SER_ZERO_SKIP_EN
module word_next_sel #(
  parameter int N = 16
) (
  input  logic [N-1:0]         mask_i,
  output logic [$clog2(N)-1:0] idx_o,
  output logic                 found_o
);

  localparam int IW = $clog2(N);

  // Priority encoder: scanning high to low leaves the lowest set bit as winner
  always_comb begin
    idx_o   = {IW{1'b0}};
    found_o = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      if (mask_i[i]) begin
        idx_o   = IW'(i);
        found_o = 1'b1;
      end
    end
  end

endmodule
`endif

// File: rtl/word_serializer.sv
// Line-to-word serializer: accepts a WORDS_PER_ENTRY-word line and emits it one
// word per handshake, ascending index, with back-to-back line capture on the
// last word. Optional macro WORD_SER_ZERO_SKIP_EN suppresses all-zero words
// (index keeps the original position; an all-zero line emits only its last word).
// WORDS_PER_ENTRY must be at least 2.
module word_serializer
  import comp_pkg::*;
#(
  parameter int DATA_WIDTH      = CP_DATA_WIDTH,
  parameter int WORDS_PER_ENTRY = CP_WORDS_PER_ENTRY
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic                                  line_valid,
  output logic                                  line_ready,
  input  logic [WORDS_PER_ENTRY*DATA_WIDTH-1:0] line_data,
  output logic                                  word_valid,
  input  logic                                  word_ready,
  output logic [DATA_WIDTH-1:0]                 word_data,
  output logic [$clog2(WORDS_PER_ENTRY)-1:0]    word_index,
  output logic                                  word_last
);

  localparam int IW = $clog2(WORDS_PER_ENTRY);
  localparam int LW = WORDS_PER_ENTRY * DATA_WIDTH;
  localparam logic [IW-1:0] LAST_IDX = IW'(WORDS_PER_ENTRY - 1);

  ser_state_e              state_q;
  logic [LW-1:0]           line_q;
  logic                    word_valid_q;
  logic [DATA_WIDTH-1:0]   word_data_q;
  logic [IW-1:0]           word_index_q;
  logic                    word_last_q;

  logic                    take_s;
  logic                    adv_s;
  logic                    done_s;
  logic                    cap_s;
  logic                    load_s;
  logic [LW-1:0]           src_line_s;
  logic [IW-1:0]           idx_d;
  logic                    last_d;
  logic [DATA_WIDTH-1:0]   data_d;

  assign take_s     = word_valid_q & word_ready;
  assign adv_s      = take_s & ~word_last_q;
  assign done_s     = take_s & word_last_q;
  // Ready in IDLE, or exactly on the last-word handshake so the next line
  // can be captured without a bubble.
  assign line_ready = (state_q == IDLE) | done_s;
  assign cap_s      = line_valid & line_ready;
  assign load_s     = cap_s | adv_s;
  assign src_line_s = cap_s ? line_data : line_q;

`ifdef WORD_SER_ZERO_SKIP_EN
  // Bits of words still to be emitted after the current one
  logic [WORDS_PER_ENTRY-1:0] rem_q;
  logic [WORDS_PER_ENTRY-1:0] rem_d;
  logic [WORDS_PER_ENTRY-1:0] nz_s;
  logic [WORDS_PER_ENTRY-1:0] sel_mask_s;
  logic [IW-1:0]              sel_idx_s;
  logic                       sel_found_s;

  // Per-word nonzero flags of the incoming line
  always_comb begin
    nz_s = {WORDS_PER_ENTRY{1'b0}};
    for (int i = 0; i < WORDS_PER_ENTRY; i++) begin
      nz_s[i] = |line_data[i*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  // One encoder serves both capture (fresh mask) and advance (remaining mask)
  assign sel_mask_s = cap_s ? nz_s : rem_q;

  word_next_sel #(
    .N (WORDS_PER_ENTRY)
  ) u_next_sel (
    .mask_i  (sel_mask_s),
    .idx_o   (sel_idx_s),
    .found_o (sel_found_s)
  );

  // Next word: lowest pending nonzero word; an all-zero line falls back to the last slot
  always_comb begin
    idx_d = sel_found_s ? sel_idx_s : LAST_IDX;
    rem_d = {WORDS_PER_ENTRY{1'b0}};
    for (int i = 0; i < WORDS_PER_ENTRY; i++) begin
      rem_d[i] = sel_mask_s[i] & (idx_d != IW'(i));
    end
    last_d = (rem_d == {WORDS_PER_ENTRY{1'b0}});
  end
`else
  // Next word: index 0 on capture, otherwise the following index
  always_comb begin
    if (cap_s) begin
      idx_d = {IW{1'b0}};
    end else begin
      idx_d = word_index_q + IW'(1);
    end
    last_d = (idx_d == LAST_IDX);
  end
`endif

  // Word mux: select the chosen word out of the line being loaded or held
  always_comb begin
    data_d = {DATA_WIDTH{1'b0}};
    for (int i = 0; i < WORDS_PER_ENTRY; i++) begin
      if (idx_d == IW'(i)) begin
        data_d = src_line_s[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // FSM with registered word outputs; outputs are forced to zero whenever idle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      line_q       <= {LW{1'b0}};
      word_valid_q <= 1'b0;
      word_data_q  <= {DATA_WIDTH{1'b0}};
      word_index_q <= {IW{1'b0}};
      word_last_q  <= 1'b0;
`ifdef WORD_SER_ZERO_SKIP_EN
      rem_q        <= {WORDS_PER_ENTRY{1'b0}};
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (cap_s) begin
            state_q      <= SEND;
            line_q       <= src_line_s;
            word_valid_q <= 1'b1;
            word_data_q  <= data_d;
            word_index_q <= idx_d;
            word_last_q  <= last_d;
`ifdef WORD_SER_ZERO_SKIP_EN
            rem_q        <= rem_d;
`endif
          end
        end
        SEND: begin
          if (load_s) begin
            line_q       <= src_line_s;
            word_valid_q <= 1'b1;
            word_data_q  <= data_d;
            word_index_q <= idx_d;
            word_last_q  <= last_d;
`ifdef WORD_SER_ZERO_SKIP_EN
            rem_q        <= rem_d;
`endif
          end else if (done_s) begin
            state_q      <= IDLE;
            word_valid_q <= 1'b0;
            word_data_q  <= {DATA_WIDTH{1'b0}};
            word_index_q <= {IW{1'b0}};
            word_last_q  <= 1'b0;
          end
        end
        default: begin
          state_q      <= IDLE;
          word_valid_q <= 1'b0;
          word_data_q  <= {DATA_WIDTH{1'b0}};
          word_index_q <= {IW{1'b0}};
          word_last_q  <= 1'b0;
        end
      endcase
    end
  end

  assign word_valid = word_valid_q;
  assign word_data  = word_data_q;
  assign word_index = word_index_q;
  assign word_last  = word_last_q;

endmodule

// File: tb/tb_word_serializer.sv
// Scoreboard bench for word_serializer: stimulus pushes expected words into a
// queue, a negedge monitor pops and compares on every word handshake.
module tb_word_serializer;

  localparam int DW  = 32;
  localparam int WPE = 16;
  localparam int IW  = 4;
  localparam int LW  = DW * WPE;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          line_valid = 1'b0;
  logic          line_ready;
  logic [LW-1:0] line_data = '0;
  logic          word_valid;
  logic          word_ready = 1'b0;
  logic [DW-1:0] word_data;
  logic [IW-1:0] word_index;
  logic          word_last;

  word_serializer #(
    .DATA_WIDTH      (DW),
    .WORDS_PER_ENTRY (WPE)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .line_valid (line_valid),
    .line_ready (line_ready),
    .line_data  (line_data),
    .word_valid (word_valid),
    .word_ready (word_ready),
    .word_data  (word_data),
    .word_index (word_index),
    .word_last  (word_last)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [DW-1:0] d;
    logic [IW-1:0] i;
    logic          l;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_err = 0;
  int   valid_cnt = 0;
  int   lr_busy_cnt = 0;

  logic          prev_stall = 1'b0;
  logic [DW-1:0] prev_d;
  logic [IW-1:0] prev_i;
  logic          prev_l;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push_exp(input logic [DW-1:0] d, input int idx, input logic l);
    exp_t e;
    e.d = d;
    e.i = IW'(idx);
    e.l = l;
    sb_q.push_back(e);
  endtask

  function automatic logic [LW-1:0] mk_line(input logic [DW-1:0] base);
    logic [LW-1:0] v;
    v = '0;
    for (int i = 0; i < WPE; i++) v[i*DW +: DW] = base + DW'(i);
    return v;
  endfunction

  // Expected full line: base+i at index i, last only on index WPE-1
  task automatic push_line(input logic [DW-1:0] base);
    for (int i = 0; i < WPE; i++) push_exp(base + DW'(i), i, (i == WPE - 1));
  endtask

  // Monitor: protocol checks every cycle and scoreboard pop on handshake
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      prev_stall = 1'b0;
    end else begin
      if (word_valid) valid_cnt++;
      if (word_valid && line_ready) lr_busy_cnt++;
      chk("line_ready", line_ready, (!word_valid) || (word_ready && word_last));
      if (prev_stall) begin
        chk("stall_valid", word_valid, 1'b1);
        chk("stall_data", word_data, prev_d);
        chk("stall_index", word_index, prev_i);
        chk("stall_last", word_last, prev_l);
      end
      if (word_valid && word_ready) begin
        if (sb_q.size() == 0) begin
          n_checks++;
          n_err++;
          $display("FAIL unexpected_word: got data 0x%0h index %0d, expected none", word_data, word_index);
        end else begin
          e = sb_q.pop_front();
          chk("word_data", word_data, e.d);
          chk("word_index", word_index, e.i);
          chk("word_last", word_last, e.l);
        end
      end
      prev_stall = word_valid && !word_ready;
      prev_d = word_data;
      prev_i = word_index;
      prev_l = word_last;
    end
  end

  // Wait, with a cycle budget, until all expected words have been seen and the DUT is idle
  task automatic wait_drain(input string name, input int budget);
    int k;
    k = 0;
    while ((sb_q.size() != 0 || word_valid) && k < budget) begin
      @(posedge clk);
      #1;
      k++;
    end
    chk({name, "_drain_in_budget"}, (k < budget), 1'b1);
  endtask

  task automatic chk_idle(input string name);
    chk({name, "_valid"}, word_valid, 1'b0);
    chk({name, "_data"}, word_data, '0);
    chk({name, "_index"}, word_index, '0);
    chk({name, "_last"}, word_last, 1'b0);
    chk({name, "_line_ready"}, line_ready, 1'b1);
  endtask

  // Offer one line for a single cycle; returns #1 after the capture edge
  task automatic send_line(input logic [LW-1:0] l);
    line_data = l;
    line_valid = 1'b1;
    @(posedge clk);
    #1;
    line_valid = 1'b0;
  endtask

  initial begin
    int vc0;
    int lr0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk_idle("reset");
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk_idle("post_reset");

    // Full line, downstream always ready, 1-cycle latency
    word_ready = 1'b1;
    push_line(32'h1000_0000);
    send_line(mk_line(32'h1000_0000));
    chk("lat_valid", word_valid, 1'b1);
    chk("lat_index", word_index, 4'd0);
    chk("lat_data", word_data, 32'h1000_0000);
    wait_drain("line1", 40);
    chk_idle("line1_end");

    // Backpressure: ready alternates 0/1, 32 valid cycles for 16 words
    word_ready = 1'b0;
    push_line(32'h5A00_0000);
    vc0 = valid_cnt;
    send_line(mk_line(32'h5A00_0000));
    chk("bp_first_valid", word_valid, 1'b1);
    for (int c = 0; c < 32; c++) begin
      word_ready = (c % 2 == 1);
      @(posedge clk);
      #1;
    end
    word_ready = 1'b1;
    chk("bp_valid_cycles", valid_cnt - vc0, 32);
    chk("bp_done_valid", word_valid, 1'b0);
    chk("bp_sb_empty", sb_q.size(), 0);

    // Two lines back-to-back with line_valid held high: no bubble
    push_line(32'hA000_0000);
    push_line(32'hB000_0000);
    vc0 = valid_cnt;
    lr0 = lr_busy_cnt;
    line_data = mk_line(32'hA000_0000);
    line_valid = 1'b1;
    @(posedge clk);
    #1;
    line_data = mk_line(32'hB000_0000);
    repeat (16) @(posedge clk);
    #1;
    line_valid = 1'b0;
    chk("b2b_second_index0", word_index, 4'd0);
    chk("b2b_second_data0", word_data, 32'hB000_0000);
    repeat (16) @(posedge clk);
    #1;
    chk("b2b_valid_cycles", valid_cnt - vc0, 32);
    chk("b2b_end_valid", word_valid, 1'b0);
    chk("b2b_line_ready_busy", lr_busy_cnt - lr0, 2);
    chk("b2b_sb_empty", sb_q.size(), 0);

    // Reset after the 5th word is accepted
    for (int i = 0; i < 5; i++) push_exp(32'h2000_0000 + i, i, 1'b0);
    send_line(mk_line(32'h2000_0000));
    repeat (5) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk_idle("mid_reset");
    chk("mid_reset_sb_empty", sb_q.size(), 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk_idle("mid_reset_release");
    push_line(32'h3000_0000);
    send_line(mk_line(32'h3000_0000));
    chk("after_reset_index0", word_index, 4'd0);
    chk("after_reset_data0", word_data, 32'h3000_0000);
    wait_drain("after_reset", 40);

`ifdef WORD_SER_ZERO_SKIP_EN
    // Sparse line: only words 2, 7, 15 nonzero
    begin
      logic [LW-1:0] sp;
      sp = '0;
      sp[2*DW +: DW]  = 32'h0000_000A;
      sp[7*DW +: DW]  = 32'h0000_000B;
      sp[15*DW +: DW] = 32'h0000_000C;
      push_exp(32'h0000_000A, 2, 1'b0);
      push_exp(32'h0000_000B, 7, 1'b0);
      push_exp(32'h0000_000C, 15, 1'b1);
      vc0 = valid_cnt;
      send_line(sp);
      chk("skip_first_index", word_index, 4'd2);
      wait_drain("skip_sparse", 20);
      chk("skip_valid_cycles", valid_cnt - vc0, 3);
      push_exp(32'h0000_0000, 15, 1'b1);
      send_line('0);
      chk("skip_zero_index", word_index, 4'd15);
      chk("skip_zero_last", word_last, 1'b1);
      wait_drain("skip_zero", 20);
    end
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

  // Watchdog against a hung run
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

endmodule
